// File: rtl/uart_cmd_bridge.sv
// UART byte-stream command responder: 'W'/'R' peek/poke over a req/ack memory bus,
// one response byte per command ('K', read data, '?' or 'T').
module uart_cmd_bridge #(
    parameter int unsigned ADDR_BYTES  = 2,
    parameter int unsigned GAP_TIMEOUT = 1200000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [7:0]              uart_rx_data_i,
    input  logic                    uart_valid_i,
    output logic                    uart_rd_o,
    output logic [7:0]              uart_tx_data_o,
    output logic                    uart_wr_o,
    input  logic                    uart_busy_i,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [8*ADDR_BYTES-1:0] bus_addr_o,
    output logic [7:0]              bus_wdata_o,
    input  logic [7:0]              bus_rdata_i,
    input  logic                    bus_ack_i
);

    localparam int unsigned ADDR_W = 8 * ADDR_BYTES;
    localparam int unsigned GAP_W  = $clog2(GAP_TIMEOUT + 1);
    localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned CNT_W  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_BAD   = 8'h3F;
    localparam logic [7:0] RSP_TOUT  = 8'h54;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4,
        HOLD = 3'd5
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic                req_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          wdata_q;
    logic [7:0]          tx_data_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [GAP_W-1:0]    gap_q;
    logic [ACK_W-1:0]    ack_cnt_q;
    logic                accept_state;

    // Bytes are only pulled from the UART while a command is being assembled.
    assign accept_state = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
    assign uart_rd_o    = !reset_i && uart_valid_i && accept_state;

    assign bus_req_o      = req_q;
    assign bus_we_o       = we_q;
    assign bus_addr_o     = addr_q;
    assign bus_wdata_o    = wdata_q;
    assign uart_wr_o      = wr_q;
    assign uart_tx_data_o = tx_data_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            ack_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (uart_valid_i) begin
                        cnt_q <= '0;
                        gap_q <= '0;
                        if (uart_rx_data_i == CMD_WRITE || uart_rx_data_i == CMD_READ) begin
                            we_q    <= (uart_rx_data_i == CMD_WRITE);
                            state_q <= ADDR;
                        end else begin
                            tx_data_q <= RSP_BAD;
                            state_q   <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (uart_valid_i) begin
                        gap_q  <= '0;
                        addr_q <= ADDR_W'({addr_q, uart_rx_data_i});
                        if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                            if (we_q) begin
                                state_q <= DATA;
                            end else begin
                                req_q     <= 1'b1;
                                ack_cnt_q <= '0;
                                state_q   <= BUS;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                DATA: begin
                    if (uart_valid_i) begin
                        wdata_q   <= uart_rx_data_i;
                        req_q     <= 1'b1;
                        ack_cnt_q <= '0;
                        state_q   <= BUS;
                    end else if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                BUS: begin
                    // Ack wins over a timeout expiring in the same cycle.
                    if (bus_ack_i) begin
                        req_q     <= 1'b0;
                        tx_data_q <= we_q ? RSP_OK : bus_rdata_i;
                        state_q   <= RESP;
                    end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                        req_q     <= 1'b0;
                        tx_data_q <= RSP_TOUT;
                        state_q   <= RESP;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + ACK_W'(1);
                    end
                end
                RESP: begin
                    if (!uart_busy_i) begin
                        wr_q    <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // One dead cycle lets the UART raise busy before the next command.
                    wr_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge; expected bus transactions and response bytes
// are queued as commands are sent and consumed by the output monitor.
module tb_uart_cmd_bridge;

    localparam int unsigned AB     = 2;
    localparam int unsigned GAP    = 100;
    localparam int unsigned ACK_TO = 255;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  uart_rx_data_i = '0;
    logic        uart_valid_i = 1'b0;
    logic        uart_rd_o;
    logic [7:0]  uart_tx_data_o;
    logic        uart_wr_o;
    logic        uart_busy_i = 1'b0;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [15:0] bus_addr_o;
    logic [7:0]  bus_wdata_o;
    logic [7:0]  bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;

    uart_cmd_bridge #(
        .ADDR_BYTES (AB),
        .GAP_TIMEOUT(GAP),
        .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .uart_rx_data_i(uart_rx_data_i),
        .uart_valid_i  (uart_valid_i),
        .uart_rd_o     (uart_rd_o),
        .uart_tx_data_o(uart_tx_data_o),
        .uart_wr_o     (uart_wr_o),
        .uart_busy_i   (uart_busy_i),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_rdata_i   (bus_rdata_i),
        .bus_ack_i     (bus_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_t;

    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_tx[$];
    bus_t exp_bus[$];
    bus_t cur_bus;
    logic [7:0] exp_byte;
    int   req_len = 0;
    int   last_req_len = 0;
    int   req_pulses = 0;
    logic req_prev = 1'b0;
    logic wr_prev = 1'b0;
    logic busy_at_edge = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) busy_at_edge <= uart_busy_i;

    // Output monitor: bus requests and transmitted bytes against the scoreboard.
    always @(negedge clk) begin
        if (bus_req_o && !req_prev) begin
            req_pulses++;
            req_len = 0;
            check("bus_expected", 32'(exp_bus.size() != 0), 1);
            if (exp_bus.size() != 0) begin
                cur_bus = exp_bus.pop_front();
                check("bus_we", 32'(bus_we_o), 32'(cur_bus.we));
                check("bus_addr", 32'(bus_addr_o), 32'(cur_bus.addr));
                if (cur_bus.we) check("bus_wdata", 32'(bus_wdata_o), 32'(cur_bus.wdata));
            end
        end else if (bus_req_o) begin
            check("bus_addr_stable", 32'(bus_addr_o), 32'(cur_bus.addr));
            check("bus_we_stable", 32'(bus_we_o), 32'(cur_bus.we));
        end
        if (bus_req_o) req_len++;
        else if (req_prev) last_req_len = req_len;
        req_prev = bus_req_o;

        if (uart_wr_o) begin
            check("tx_expected", 32'(exp_tx.size() != 0), 1);
            check("tx_busy_clear", 32'(busy_at_edge), 0);
            check("wr_one_cycle", 32'(wr_prev), 0);
            if (exp_tx.size() != 0) begin
                exp_byte = exp_tx.pop_front();
                check("tx_byte", 32'(uart_tx_data_o), 32'(exp_byte));
            end
        end
        wr_prev = uart_wr_o;
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        @(negedge clk);
        uart_valid_i   = 1'b1;
        uart_rx_data_i = b;
        for (int i = 0; i < 2000 && !got; i++) begin
            #1;
            if (uart_rd_o) got = 1'b1;
            else @(negedge clk);
        end
        check("rd_seen", 32'(got), 1);
        if (got) begin
            @(posedge clk);
            #1;
        end
        uart_valid_i = 1'b0;
    endtask

    task automatic wait_req();
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus_req_o) got = 1'b1;
        end
        check("req_seen", 32'(got), 1);
    endtask

    task automatic ack_after(input int n, input logic [7:0] rdata);
        wait_req();
        repeat (n) @(negedge clk);
        bus_ack_i   = 1'b1;
        bus_rdata_i = rdata;
        @(negedge clk);
        bus_ack_i = 1'b0;
    endtask

    task automatic wait_tx_empty(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (exp_tx.size() == 0) break;
        end
        check("tx_done", 32'(exp_tx.size()), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd"}, 32'(uart_rd_o), 0);
        check({tag, "_wr"}, 32'(uart_wr_o), 0);
        check({tag, "_txd"}, 32'(uart_tx_data_o), 0);
        check({tag, "_req"}, 32'(bus_req_o), 0);
        check({tag, "_we"}, 32'(bus_we_o), 0);
        check({tag, "_addr"}, 32'(bus_addr_o), 0);
        check({tag, "_wdata"}, 32'(bus_wdata_o), 0);
    endtask

    initial begin
        // Reset, with a byte waiting that must not be consumed.
        uart_valid_i   = 1'b1;
        uart_rx_data_i = 8'h57;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        uart_valid_i = 1'b0;
        reset_i      = 1'b0;

        // Write 0x1234 <= 0xA5, ack three cycles after request.
        exp_bus.push_back('{1'b1, 16'h1234, 8'hA5});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
        ack_after(3, 8'h00);
        wait_tx_empty(50);
        check("write_req_len", 32'(last_req_len), 4);
        check("write_pulses", 32'(req_pulses), 1);

        // Read 0x0010 with transmitter busy until well after the ack.
        uart_busy_i = 1'b1;
        exp_bus.push_back('{1'b0, 16'h0010, 8'h00});
        exp_tx.push_back(8'hC3);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        ack_after(1, 8'hC3);
        repeat (10) @(negedge clk);
        check("held_while_busy", 32'(exp_tx.size()), 1);
        uart_busy_i = 1'b0;
        wait_tx_empty(20);

        // Unknown command, then a normal read.
        exp_tx.push_back(8'h3F);
        send_byte(8'h00);
        wait_tx_empty(20);
        check("unknown_no_bus", 32'(req_pulses), 2);
        exp_bus.push_back('{1'b0, 16'h0001, 8'h00});
        exp_tx.push_back(8'h77);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
        ack_after(0, 8'h77);
        wait_tx_empty(20);

        // Ack timeout, followed by a late ack that must be ignored.
        exp_bus.push_back('{1'b0, 16'h0001, 8'h00});
        exp_tx.push_back(8'h54);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
        wait_req();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!bus_req_o) break;
        end
        #1;
        check("ack_timeout_len", 32'(last_req_len), ACK_TO);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 8'hEE;
        @(negedge clk);
        bus_ack_i = 1'b0;
        wait_tx_empty(20);
        repeat (5) @(negedge clk);

        // Inter-byte gap timeout drops the partial write silently.
        send_byte(8'h57); send_byte(8'h12);
        repeat (GAP + 1) @(negedge clk);
        check("gap_no_bus", 32'(req_pulses), 4);
        exp_bus.push_back('{1'b0, 16'h0002, 8'h00});
        exp_tx.push_back(8'h5A);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
        ack_after(2, 8'h5A);
        wait_tx_empty(20);

        // Reset during a bus write aborts with no response.
        exp_bus.push_back('{1'b1, 16'h0003, 8'h99});
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h03); send_byte(8'h99);
        wait_req();
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        reset_i = 1'b0;
        repeat (20) @(negedge clk);
        exp_tx.push_back(8'h3F);
        send_byte(8'h00);
        wait_tx_empty(20);

        check("bus_queue_empty", 32'(exp_bus.size()), 0);
        check("total_pulses", 32'(req_pulses), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
